// File: rtl/bumpy_pkg.sv
// bumpy_pkg: shared definitions for the Bumpy movement FSM and the position
// integrator (bumpy_move).
//   state_t     : 4-bit FSM state code seen on bumpy_move's `state` input
//   BOTTOM..LEFT: bit positions inside HitEdgeCode {Left,Top,Right,Bottom}
//   tile_t      : tile type codes used by the collision logic
//   move_dbg_t  : internal state of bumpy_move exposed for observation
package bumpy_pkg;

  typedef enum logic [3:0] {
    Sreset             = 4'd0,
    Sidle              = 4'd1,
    Sleft              = 4'd2,
    Sright             = 4'd3,
    Sdown              = 4'd4,
    Sup                = 4'd5,
    Sdie               = 4'd6,
    Sbounce_from_left  = 4'd7,
    Sbounce_from_right = 4'd8,
    Sbounce_from_top   = 4'd9,
    Sdown_from_right   = 4'd10,
    Sdown_from_left    = 4'd11
  } state_t;

  // Bit positions in HitEdgeCode.
  localparam int BOTTOM = 0;
  localparam int RIGHT  = 1;
  localparam int TOP    = 2;
  localparam int LEFT   = 3;

  // A landing requires the bottom edge and nothing else.
  localparam logic [3:0] EDGE_BOTTOM_ONLY = 4'b0001;

  typedef enum logic [2:0] {
    FREE  = 3'd0,
    REGU  = 3'd1,
    GATE  = 3'd2,
    DEATH = 3'd3,
    WALL  = 3'd4
  } tile_t;

  typedef struct packed {
    logic [3:0] state_d;
    logic [6:0] fcnt;
    logic       landed;
  } move_dbg_t;

  // Codes above Sdown_from_left are not produced by a healthy FSM.
  function automatic logic is_known_state(logic [3:0] s);
    return s <= 4'd11;
  endfunction

endpackage

// File: rtl/bumpy_move_if.sv
// bumpy_move_if: link between the movement FSM (master) and the position
// integrator (slave).
//   startOfFrame    : one-cycle frame tick
//   state           : FSM state code (bumpy_pkg::state_t encoding)
//   bumpy_collision : sprite/tile overlap this cycle
//   HitEdgeCode     : {Left,Top,Right,Bottom} edges touched
//   topLeftX/Y      : Bumpy's top-left pixel coordinates
//   dead            : one-cycle pulse when the death delay expires
// Signalling: there is no valid/ready pair. Inputs are sampled on every clk
// edge; startOfFrame and dead are single-cycle strobes, state and the
// coordinates are levels that hold until changed.
interface bumpy_move_if;
  logic               startOfFrame;
  logic [3:0]         state;
  logic               bumpy_collision;
  logic [3:0]         HitEdgeCode;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               dead;

  modport master (
    output startOfFrame, state, bumpy_collision, HitEdgeCode,
    input  topLeftX, topLeftY, dead
  );

  modport slave (
    input  startOfFrame, state, bumpy_collision, HitEdgeCode,
    output topLeftX, topLeftY, dead
  );
endinterface

// File: rtl/bumpy_frame_timer.sv
// bumpy_frame_timer: frames elapsed since the last state entry.
//   clk, reset : clock, synchronous active-high reset
//   clear      : state entry, restarts the count at 0
//   tick       : count one frame (saturates at 127)
//   fcnt       : current count
//   hit_*      : the count is about to reach BOUNCE_FRAMES, 2*BOUNCE_FRAMES,
//                SLIDE_FRAMES or DIE_FRAMES on this tick. The speed rules
//                act on the incremented value, so the compare looks ahead.
module bumpy_frame_timer #(
  parameter int BOUNCE_FRAMES = 8,
  parameter int SLIDE_FRAMES  = 32,
  parameter int DIE_FRAMES    = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       tick,
  output logic [6:0] fcnt,
  output logic       hit_bounce,
  output logic       hit_bounce2,
  output logic       hit_slide,
  output logic       hit_die
);

  logic [6:0] fcnt_inc;

  assign fcnt_inc = (fcnt == 7'd127) ? fcnt : fcnt + 7'd1;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      fcnt <= 7'd0;
    end else if (tick) begin
      fcnt <= fcnt_inc;
    end
  end

  // A saturated counter never produces a fresh equality below 127.
  assign hit_bounce  = (fcnt != 7'd127) && (fcnt_inc == 7'(BOUNCE_FRAMES));
  assign hit_bounce2 = (fcnt != 7'd127) && (fcnt_inc == 7'(2 * BOUNCE_FRAMES));
  assign hit_slide   = (fcnt != 7'd127) && (fcnt_inc == 7'(SLIDE_FRAMES));
  assign hit_die     = (fcnt != 7'd127) && (fcnt_inc == 7'(DIE_FRAMES));

endmodule

// File: rtl/bumpy_move.sv
// bumpy_move: Bumpy's position integrator. Loads velocities when the FSM
// enters a state, applies gravity/landing/timed sub-motions each frame and
// integrates a 32-bit fixed-point position (scale 2**FIXED_MULT_LOG2).
//   clk, reset : clock, synchronous active-high reset
//   bus        : bumpy_move_if.slave (FSM inputs, pixel outputs, dead)
//   dbg        : registered state copy, frame count and landed flag
module bumpy_move
  import bumpy_pkg::*;
#(
  parameter int INITIAL_X       = 288,
  parameter int INITIAL_Y       = 192,
  parameter int TILE            = 32,
  parameter int FIXED_MULT_LOG2 = 6,
  parameter int X_SPEED         = 64,
  parameter int HOP_SPEED       = 192,
  parameter int GRAVITY         = 16,
  parameter int MAX_Y_SPEED     = 400,
  parameter int BOUNCE_FRAMES   = 8,
  parameter int DIE_FRAMES      = 60
) (
  input  logic        clk,
  input  logic        reset,
  bumpy_move_if.slave bus,
  output move_dbg_t   dbg
);

  localparam int FX           = 2 ** FIXED_MULT_LOG2;
  localparam int SLIDE_FRAMES = (TILE * FX) / X_SPEED;

  localparam logic signed [31:0] INIT_X_FX = 32'(INITIAL_X * FX);
  localparam logic signed [31:0] INIT_Y_FX = 32'(INITIAL_Y * FX);
  // Clears the fraction and the sub-tile pixel bits in one go.
  localparam logic [31:0]        SNAP_MASK = ~(32'(TILE * FX) - 32'd1);

  localparam logic signed [15:0] X_SPD = 16'(X_SPEED);
  localparam logic signed [15:0] HOP   = 16'(HOP_SPEED);
  localparam logic signed [15:0] HOP2  = 16'(2 * HOP_SPEED);
  localparam logic signed [15:0] GRAV  = 16'(GRAVITY);
  localparam logic signed [15:0] MAXY  = 16'(MAX_Y_SPEED);

  logic signed [31:0] pos_x, pos_y, pos_y_base;
  logic signed [15:0] x_spd, y_spd;
  logic signed [15:0] x_en, y_en, x_nx, y_nx, y_grav;
  logic [3:0]         state_d;
  logic               landed, dead_q;
  logic               entry, moving, land_now;
  logic [6:0]         fcnt;
  logic               hit_bounce, hit_bounce2, hit_slide, hit_die;

  assign entry    = (bus.state != state_d);
  assign moving   = is_known_state(state_d) && (state_d != Sreset) && (state_d != Sdie);
  assign land_now = bus.bumpy_collision && (bus.HitEdgeCode == EDGE_BOTTOM_ONLY)
                    && (y_spd > 16'sd0);

  bumpy_frame_timer #(
    .BOUNCE_FRAMES (BOUNCE_FRAMES),
    .SLIDE_FRAMES  (SLIDE_FRAMES),
    .DIE_FRAMES    (DIE_FRAMES)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .clear       (entry),
    .tick        (bus.startOfFrame && !entry && (state_d != Sreset)),
    .fcnt        (fcnt),
    .hit_bounce  (hit_bounce),
    .hit_bounce2 (hit_bounce2),
    .hit_slide   (hit_slide),
    .hit_die     (hit_die)
  );

  // Velocities loaded on entering bus.state. Sreset, Sdie and unknown codes
  // stop Bumpy; Sdown keeps the vertical speed it already has.
  always_comb begin
    x_en = 16'sd0;
    y_en = 16'sd0;
    case (bus.state)
      Sidle:              y_en = -HOP;
      Sleft:              begin x_en = -X_SPD; y_en = -HOP; end
      Sright:             begin x_en =  X_SPD; y_en = -HOP; end
      Sup:                y_en = -HOP2;
      Sdown:              y_en = y_spd;
      Sbounce_from_left:  begin x_en = -X_SPD; y_en = -HOP; end
      Sbounce_from_right: begin x_en =  X_SPD; y_en = -HOP; end
      Sbounce_from_top:   y_en = -HOP;
      Sdown_from_right:   x_en =  X_SPD;
      Sdown_from_left:    x_en = -X_SPD;
      default:            ;
    endcase
  end

  // Per-frame speed update: landing re-launch or clamped gravity first, then
  // the frame-count driven sub-motion rules.
  always_comb begin
    y_grav     = y_spd + GRAV;
    y_nx       = landed ? -HOP : ((y_grav > MAXY) ? MAXY : y_grav);
    x_nx       = x_spd;
    pos_y_base = landed ? (pos_y & SNAP_MASK) : pos_y;
    case (state_d)
      Sbounce_from_left, Sbounce_from_right: begin
        if (hit_bounce2)     x_nx = 16'sd0;
        else if (hit_bounce) x_nx = -x_spd;
      end
      Sbounce_from_top: begin
        if (hit_bounce) y_nx = 16'sd0;
      end
      Sdown_from_left, Sdown_from_right: begin
        if (hit_slide) x_nx = 16'sd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x   <= INIT_X_FX;
      pos_y   <= INIT_Y_FX;
      x_spd   <= 16'sd0;
      y_spd   <= 16'sd0;
      state_d <= 4'(Sreset);
      landed  <= 1'b0;
      dead_q  <= 1'b0;
    end else if (entry) begin
      // Entry wins over a coincident frame tick: that frame is not integrated.
      state_d <= bus.state;
      landed  <= 1'b0;
      dead_q  <= 1'b0;
      x_spd   <= x_en;
      y_spd   <= y_en;
      if (bus.state == 4'(Sreset)) begin
        pos_x <= INIT_X_FX;
        pos_y <= INIT_Y_FX;
      end
    end else if (bus.startOfFrame) begin
      // The flag is consumed by this frame; a collision seen in this same
      // cycle is kept for the next frame.
      landed <= land_now;
      dead_q <= (state_d == 4'(Sdie)) && hit_die;
      if (moving) begin
        x_spd <= x_nx;
        y_spd <= y_nx;
        pos_x <= pos_x + {{16{x_nx[15]}}, x_nx};
        pos_y <= pos_y_base + {{16{y_nx[15]}}, y_nx};
      end
    end else begin
      dead_q <= 1'b0;
      if (land_now) landed <= 1'b1;
    end
  end

  // Arithmetic shift followed by truncation to 11 bits is a plain slice.
  assign bus.topLeftX = pos_x[FIXED_MULT_LOG2 +: 11];
  assign bus.topLeftY = pos_y[FIXED_MULT_LOG2 +: 11];
  assign bus.dead     = dead_q;

  assign dbg = '{state_d: state_d, fcnt: fcnt, landed: landed};

endmodule

// File: tb/tb_bumpy_move.sv
// tb_bumpy_move: directed test of bumpy_move against a frame-level model.
module tb_bumpy_move;
  import bumpy_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bumpy_move_if bus();
  move_dbg_t    dbg;

  bumpy_move dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dbg   (dbg)
  );

  // ---------------- model state ----------------
  int         m_x, m_y, m_vx, m_vy, m_fc;
  logic       m_landed, m_dead;
  logic [3:0] m_st;
  logic [3:0] cur_s;

  int total, bad, dead_cnt;

  // {x[10:0], y[10:0], dead, state_d[3:0], fcnt[6:0], landed}
  logic [34:0] exp_q[$];

  function automatic void chk(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    end
  endfunction

  function automatic logic is_moving(logic [3:0] s);
    return s inside {Sidle, Sleft, Sright, Sdown, Sup, Sbounce_from_left,
                     Sbounce_from_right, Sbounce_from_top, Sdown_from_right,
                     Sdown_from_left};
  endfunction

  task automatic m_reset();
    m_st = Sreset; m_x = 288 * 64; m_y = 192 * 64;
    m_vx = 0; m_vy = 0; m_fc = 0; m_landed = 1'b0; m_dead = 1'b0;
  endtask

  task automatic m_enter(logic [3:0] s);
    m_st = s; m_fc = 0; m_landed = 1'b0;
    case (s)
      Sreset:             begin m_x = 288 * 64; m_y = 192 * 64; m_vx = 0; m_vy = 0; end
      Sidle:              begin m_vx = 0;   m_vy = -192; end
      Sleft:              begin m_vx = -64; m_vy = -192; end
      Sright:             begin m_vx = 64;  m_vy = -192; end
      Sup:                begin m_vx = 0;   m_vy = -384; end
      Sdown:              m_vx = 0;
      Sbounce_from_left:  begin m_vx = -64; m_vy = -192; end
      Sbounce_from_right: begin m_vx = 64;  m_vy = -192; end
      Sbounce_from_top:   begin m_vx = 0;   m_vy = -192; end
      Sdown_from_right:   begin m_vx = 64;  m_vy = 0; end
      Sdown_from_left:    begin m_vx = -64; m_vy = 0; end
      default:            begin m_vx = 0;   m_vy = 0; end
    endcase
  endtask

  task automatic m_frame(logic new_land);
    int py;
    if (m_st != Sreset) m_fc = (m_fc < 127) ? m_fc + 1 : 127;
    m_dead = (m_st == Sdie) && (m_fc == 60);
    if (is_moving(m_st)) begin
      if (m_landed) begin
        m_vy = -192;
        py   = (m_y >>> 6) & ~31;   // floor pixel Y to a tile multiple
        m_y  = py * 64;
      end else begin
        m_vy = (m_vy + 16 > 400) ? 400 : m_vy + 16;
      end
      if (m_st == Sbounce_from_left || m_st == Sbounce_from_right) begin
        if (m_fc == 8)  m_vx = -m_vx;
        if (m_fc == 16) m_vx = 0;
      end
      if (m_st == Sbounce_from_top && m_fc == 8) m_vy = 0;
      if ((m_st == Sdown_from_left || m_st == Sdown_from_right) && m_fc == 32) m_vx = 0;
      m_x = m_x + m_vx;
      m_y = m_y + m_vy;
    end
    m_landed = new_land;
  endtask

  // ---------------- driver ----------------
  task automatic cyc(logic r, logic [3:0] s, logic sof, logic coll, logic [3:0] code);
    logic land;
    reset = r; bus.state = s; bus.startOfFrame = sof;
    bus.bumpy_collision = coll; bus.HitEdgeCode = code;
    @(posedge clk);
    land   = coll && (code == 4'b0001) && (m_vy > 0);
    m_dead = 1'b0;
    if (r)               m_reset();
    else if (s != m_st)  m_enter(s);
    else if (sof)        m_frame(land);
    else if (land)       m_landed = 1'b1;
    exp_q.push_back({11'(m_x >>> 6), 11'(m_y >>> 6), m_dead, m_st, 7'(m_fc), m_landed});
    #1;
  endtask

  task automatic enter(logic [3:0] s);
    cur_s = s;
    cyc(1'b0, s, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic frame(logic coll, logic [3:0] code);
    if (coll) cyc(1'b0, cur_s, 1'b0, 1'b1, code);
    cyc(1'b0, cur_s, 1'b1, 1'b0, 4'b0000);
    cyc(1'b0, cur_s, 1'b0, 1'b0, 4'b0000);
    cyc(1'b0, cur_s, 1'b0, 1'b0, 4'b0000);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [34:0] e;
    if (bus.dead === 1'b1) dead_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("topLeftX", int'($signed(bus.topLeftX)), int'($signed(e[34:24])));
      chk("topLeftY", int'($signed(bus.topLeftY)), int'($signed(e[23:13])));
      chk("dead",     int'(bus.dead),              int'(e[12]));
      chk("state_d",  int'(dbg.state_d),           int'(e[11:8]));
      chk("fcnt",     int'(dbg.fcnt),              int'(e[7:1]));
      chk("landed",   int'(dbg.landed),            int'(e[0]));
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    total = 0; bad = 0; dead_cnt = 0;
    reset = 1'b1; cur_s = Sreset;
    bus.state = Sreset; bus.startOfFrame = 1'b0;
    bus.bumpy_collision = 1'b0; bus.HitEdgeCode = 4'b0000;
    m_reset();

    repeat (3) cyc(1'b1, Sreset, 1'b0, 1'b0, 4'b0000);
    chk("rst_x", int'($signed(bus.topLeftX)), 288);
    chk("rst_y", int'($signed(bus.topLeftY)), 192);
    chk("rst_dead", int'(bus.dead), 0);

    repeat (5) frame(1'b0, 4'b0000);
    chk("sreset_hold_x", int'($signed(bus.topLeftX)), 288);
    chk("sreset_hold_y", int'($signed(bus.topLeftY)), 192);

    // Idle hop: -176 after one frame, apex after twelve.
    enter(Sidle);
    frame(1'b0, 4'b0000);
    chk("lit_idle_vy1", m_vy, -176);
    chk("lit_idle_y1", m_y >>> 6, 189);
    chk("dut_idle_y1", int'($signed(bus.topLeftY)), 189);
    repeat (11) frame(1'b0, 4'b0000);
    chk("lit_idle_vy12", m_vy, 0);
    chk("lit_idle_y12", m_y >>> 6, 175);

    // Walk left with collisions on every frame; only descending bottom-only
    // hits may land (frame 14 carries a bottom+right code).
    enter(Sleft);
    for (int i = 1; i <= 16; i++) begin
      frame(1'b1, (i == 14) ? 4'b0011 : 4'b0001);
      if (i == 10) chk("lit_left_x10", m_x >>> 6, 278);
      if (i == 14) chk("lit_left_y14", m_y >>> 6, 159);
      if (i == 15) chk("lit_left_y15", m_y >>> 6, 125);
    end
    chk("dut_left_x16", int'($signed(bus.topLeftX)), 272);

    // Entry coincident with a frame tick: no integration for that frame.
    cur_s = Sbounce_from_right;
    cyc(1'b0, Sbounce_from_right, 1'b1, 1'b0, 4'b0000);
    cyc(1'b0, Sbounce_from_right, 1'b0, 1'b0, 4'b0000);
    for (int i = 1; i <= 20; i++) begin
      frame(1'b0, 4'b0000);
      if (i == 8)  chk("lit_bounce_x8", m_x >>> 6, 278);
      if (i == 16) chk("lit_bounce_x16", m_x >>> 6, 271);
    end
    chk("dut_bounce_x20", int'($signed(bus.topLeftX)), 271);

    enter(Sbounce_from_top);
    for (int i = 1; i <= 10; i++) begin
      frame(1'b0, 4'b0000);
      if (i == 8) chk("lit_top_vy8", m_vy, 0);
    end

    enter(Sdown_from_left);
    repeat (40) frame(1'b0, 4'b0000);
    chk("lit_slide_x", m_x >>> 6, 240);
    chk("lit_slide_vy", m_vy, 400);

    enter(Sdown);
    repeat (3) frame(1'b0, 4'b0000);
    chk("lit_down_vy", m_vy, 400);

    enter(Sup);
    repeat (2) frame(1'b0, 4'b0000);
    chk("lit_up_vy", m_vy, -352);

    // Unknown code freezes like Sdie.
    enter(4'd13);
    repeat (3) frame(1'b0, 4'b0000);
    chk("lit_unk_fc", m_fc, 3);

    enter(Sdie);
    repeat (65) frame(1'b0, 4'b0000);
    chk("die_pulse_count", dead_cnt, 1);

    // Re-enter death, then reset before the delay expires.
    enter(Sidle);
    enter(Sdie);
    repeat (30) frame(1'b0, 4'b0000);
    cur_s = Sreset;
    cyc(1'b1, Sreset, 1'b0, 1'b0, 4'b0000);
    repeat (3) frame(1'b0, 4'b0000);
    chk("die_reset_count", dead_cnt, 1);
    chk("die_reset_x", int'($signed(bus.topLeftX)), 288);
    chk("die_reset_y", int'($signed(bus.topLeftY)), 192);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
